result_display: RTL and testbench

Converts the signed two's-complement product from the Booth multiplier into sign plus decimal digits. It uses a sequential double-dabble (shift/add-3) converter, one bit per clock. It also drives a multiplexed, common-anode seven-segment display with leading-zero blanking. It sits downstream of the multiplier and performs the inverse of keypad entry: binary in, decimal digits out.

---
 rtl/result_display.sv | 181 ++++++++++++++++++
 tb/tb_result_display.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/result_display.sv
// Signed binary to sign + BCD converter (serial double-dabble, one bit per clock)
// driving a multiplexed common-anode seven-segment display with leading-zero blanking.
module result_display #(
  parameter int WIDTH       = 16,
  parameter int DIGITS      = 5,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clear,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic [DIGITS:0]       anode,
  output logic [6:0]            seg
);

  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int SLOT_W = $clog2(DIGITS + 1);
  localparam int REF_W  = $clog2(REFRESH_DIV);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]      mag_q, mag_d;
  logic [4*DIGITS-1:0]   scr_q, scr_d;
  logic                  sign_q, sign_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  neg_q, neg_d;
  logic [REF_W-1:0]      ref_q, ref_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [DIGITS:0]       anode_q, anode_d;
  logic [6:0]            seg_q, seg_d;
  logic signed [WIDTH-1:0] sval;

  function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] s);
    logic [4*DIGITS-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'b1000000;
      4'd1:    r = 7'b1111001;
      4'd2:    r = 7'b0100100;
      4'd3:    r = 7'b0110000;
      4'd4:    r = 7'b0011001;
      4'd5:    r = 7'b0010010;
      4'd6:    r = 7'b0000010;
      4'd7:    r = 7'b1111000;
      4'd8:    r = 7'b0000000;
      4'd9:    r = 7'b0010000;
      default: r = SEG_BLANK;
    endcase
    return r;
  endfunction

  // A digit slot is blanked when it and every more-significant digit are zero;
  // the units slot always shows.
  function automatic logic [6:0] slot_seg(input logic [SLOT_W-1:0] s,
                                          input logic [4*DIGITS-1:0] b,
                                          input logic n);
    logic [6:0] r;
    logic       nz;
    r = SEG_BLANK;
    if (s == SLOT_W'(DIGITS)) r = n ? SEG_MINUS : SEG_BLANK;
    for (int i = 0; i < DIGITS; i++) begin
      nz = 1'b0;
      for (int j = 0; j < DIGITS; j++) begin
        if (j >= i) nz = nz | (|b[4*j +: 4]);
      end
      if ((s == SLOT_W'(i)) && ((i == 0) || nz)) r = digit_seg(b[4*i +: 4]);
    end
    return r;
  endfunction

  assign sval = value;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    scr_d   = scr_q;
    sign_d  = sign_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      bcd_d   = '0;
      neg_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (start) begin
            state_d = SHIFT;
            cnt_d   = '0;
            sign_d  = sval[WIDTH-1];
            mag_d   = sval[WIDTH-1] ? WIDTH'(-sval) : value;
            scr_d   = '0;
          end
        end
        SHIFT: begin
          // WIDTH shift cycles, then one settle cycle that publishes the result.
          if (cnt_q == CNT_W'(WIDTH)) begin
            state_d = DONE;
            bcd_d   = scr_q;
            neg_d   = sign_q;
          end else begin
            {scr_d, mag_d} = {add3(scr_q), mag_q} << 1;
            cnt_d          = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Scan: anode and segments are registered from the same next-state slot so they
  // always agree; segments also pick up a new result in the cycle it is published.
  always_comb begin
    ref_d  = ref_q + 1'b1;
    slot_d = slot_q;
    if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_d  = '0;
      slot_d = (slot_q == SLOT_W'(DIGITS)) ? '0 : slot_q + 1'b1;
    end
    anode_d = ~((DIGITS+1)'(1) << slot_d);
    seg_d   = slot_seg(slot_d, bcd_d, neg_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ref_q   <= '0;
      slot_q  <= '0;
      anode_q <= {{DIGITS{1'b1}}, 1'b0};
      seg_q   <= SEG_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      ref_q   <= ref_d;
      slot_q  <= slot_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
    end
  end

  always_ff @(posedge clk) begin
    mag_q  <= mag_d;
    scr_q  <= scr_d;
    sign_q <= sign_d;
  end

  assign busy  = (state_q == SHIFT);
  assign done  = (state_q == DONE);
  assign bcd   = bcd_q;
  assign neg   = neg_q;
  assign anode = anode_q;
  assign seg   = seg_q;

endmodule

// File: tb/tb_result_display.sv
// Scoreboard bench for result_display: the driver queues expected results, a
// monitor checks them whenever done pulses.
module tb_result_display;
  localparam int W = 16, D = 5, RD = 4;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S6 = 7'b0000010,
                         S7 = 7'b1111000, S8 = 7'b0000000, BL = 7'b1111111,
                         MI = 7'b0111111;

  logic           clk = 1'b0, rst = 1'b0, start = 1'b0, clear = 1'b0;
  logic [W-1:0]   value = '0;
  logic           busy, done, neg;
  logic [4*D-1:0] bcd;
  logic [D:0]     anode;
  logic [6:0]     seg;

  result_display #(.WIDTH(W), .DIGITS(D), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .value(value),
    .busy(busy), .done(done), .bcd(bcd), .neg(neg), .anode(anode), .seg(seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4*D-1:0] bcd;
    logic           neg;
    logic [31:0]    t;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_bcd", 32'(bcd), 32'(mon_e.bcd));
        check("done_neg", 32'(neg), 32'(mon_e.neg));
        check("done_time", 32'($time), mon_e.t);
        check("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic push_exp(input logic [4*D-1:0] eb, input logic en);
    exp_t e;
    e.bcd = eb;
    e.neg = en;
    e.t   = 32'($time) + 32'd175;
    sb.push_back(e);
  endtask

  task automatic convert(input logic [W-1:0] v, input logic [4*D-1:0] eb, input logic en);
    @(negedge clk); value = v; start = 1'b1;
    @(posedge clk); push_exp(eb, en);
    @(negedge clk); start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    repeat (20) @(negedge clk);
  endtask

  task automatic scan(input logic [5:0][6:0] es, input string tag);
    int         guard;
    int         cnt;
    logic [5:0] an;
    guard = 0;
    while (anode == 6'b111110 && guard < 40) begin @(negedge clk); guard++; end
    guard = 0;
    while (anode != 6'b111110 && guard < 40) begin @(negedge clk); guard++; end
    for (int k = 0; k < 6; k++) begin
      an = ~(6'b1 << k);
      check($sformatf("%s_anode%0d", tag, k), 32'(anode), 32'(an));
      check($sformatf("%s_seg%0d", tag, k), 32'(seg), 32'(es[k]));
      cnt = 0;
      do begin @(negedge clk); cnt++; end while (anode == an && cnt < 20);
      check($sformatf("%s_dwell%0d", tag, k), 32'(cnt), 32'(RD));
    end
    check($sformatf("%s_wrap", tag), 32'(anode), 32'(6'b111110));
  endtask

  initial begin
    int guard;
    int cnt;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_neg", 32'(neg), 32'd0);
    check("rst_anode", 32'(anode), 32'(6'b111110));
    check("rst_seg", 32'(seg), 32'(S0));
    rst = 1'b1;

    convert(16'd1234, 20'h01234, 1'b0);
    scan({BL, BL, S1, S2, S3, S4}, "p1234");
    convert(16'h8000, 20'h32768, 1'b1);
    scan({MI, S3, S2, S7, S6, S8}, "m32768");
    convert(16'd0, 20'h00000, 1'b0);
    scan({BL, BL, BL, BL, BL, S0}, "zero");
    convert(16'hFFFF, 20'h00001, 1'b1);

    // start pulsed mid-conversion is ignored
    @(negedge clk); value = 16'd4321; start = 1'b1;
    @(posedge clk); push_exp(20'h04321, 1'b0);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    value = 16'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    check("ignored_start_bcd", 32'(bcd), 32'h04321);

    // start held through done: back-to-back conversion
    @(negedge clk); value = 16'd100; start = 1'b1;
    @(posedge clk); push_exp(20'h00100, 1'b0);
    @(negedge clk); value = 16'd200;
    guard = 0;
    while (!done && guard < 30) begin @(negedge clk); guard++; end
    check("b2b_first_done_seen", 32'(done), 32'd1);
    @(posedge clk); push_exp(20'h00200, 1'b0);
    @(negedge clk); start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    repeat (20) @(negedge clk);

    // clear mid-conversion of 999
    @(negedge clk); value = 16'd999; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    check("clear_busy", 32'(busy), 32'd0);
    check("clear_bcd", 32'(bcd), 32'd0);
    check("clear_neg", 32'(neg), 32'd0);
    repeat (25) @(negedge clk);

    // start and clear together: clear wins
    @(negedge clk); value = 16'd55; start = 1'b1; clear = 1'b1;
    @(negedge clk); start = 1'b0; clear = 1'b0;
    check("start_clear_busy", 32'(busy), 32'd0);
    repeat (25) @(negedge clk);

    // asynchronous reset mid-conversion
    convert(16'hFFFF, 20'h00001, 1'b1);
    @(negedge clk); value = 16'd1234; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_bcd", 32'(bcd), 32'd0);
    check("arst_neg", 32'(neg), 32'd0);
    check("arst_anode", 32'(anode), 32'(6'b111110));
    check("arst_seg", 32'(seg), 32'(S0));
    @(negedge clk); rst = 1'b1;
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (anode == 6'b111110 && cnt < 20);
    check("arst_first_slot_change", 32'(cnt), 32'(RD));
    repeat (25) @(negedge clk);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
